// File: rtl/input_conditioner.sv
// input_conditioner: conditions one asynchronous, noisy single-bit input for use in the clk domain.
//   Stage 1: two-flop synchronizer (sync0 -> sync1).
//   Stage 2: counter-based debouncer. conditioned follows sync1 only after sync1 has differed
//            from it on waittime+1 consecutive clocks.
//   Stage 3: single-cycle edge pulses, registered alongside conditioned.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset; clears all state
//   noisysignal  in   raw asynchronous input
//   conditioned  out  synchronized, debounced noisysignal
//   positiveedge out  one-clock pulse in the cycle conditioned goes 0->1
//   negativeedge out  one-clock pulse in the cycle conditioned goes 1->0
// Latency: a level sampled into sync0 at edge k appears on conditioned at edge k+waittime+2.
// waittime must be in 1..2^counterwidth-1.
module input_conditioner #(
  parameter int unsigned counterwidth = 3,
  parameter int unsigned waittime     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [counterwidth-1:0] waitcount = counterwidth'(waittime);

  logic                    sync0;
  logic                    sync1;
  logic [counterwidth-1:0] counter;

  // sync0 is the only flop that sees the asynchronous input; it may go metastable
  // and is given a full cycle to resolve before sync1 samples it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= noisysignal;
      sync1 <= sync0;
    end
  end

  // Any cycle where sync1 agrees with conditioned clears the count, so a glitch or bounce
  // restarts the wait. The counter stops at waitcount and never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      conditioned  <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else if (sync1 == conditioned) begin
      counter      <= '0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else if (counter == waitcount) begin
      conditioned  <= sync1;
      counter      <= '0;
      positiveedge <= sync1;
      negativeedge <= ~sync1;
    end else begin
      counter      <= counter + 1'b1;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic clk;
  logic reset;
  logic noisysignal;
  logic conditioned;
  logic positiveedge;
  logic negativeedge;

  int tests;
  int failures;
  int pos_count;
  int neg_count;

  input_conditioner #(
    .counterwidth(3),
    .waittime    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .noisysignal (noisysignal),
    .conditioned (conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (positiveedge === 1'b1) pos_count++;
    if (negativeedge === 1'b1) neg_count++;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic c, input logic p, input logic n);
    check({tag, ".conditioned"}, {7'd0, conditioned}, {7'd0, c});
    check({tag, ".positiveedge"}, {7'd0, positiveedge}, {7'd0, p});
    check({tag, ".negativeedge"}, {7'd0, negativeedge}, {7'd0, n});
  endtask

  initial begin
    tests       = 0;
    failures    = 0;
    pos_count   = 0;
    neg_count   = 0;
    reset       = 1'b1;
    noisysignal = 1'b0;

    // Reset held: input activity must not reach the outputs.
    tick();
    check_out("reset_hold0", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      noisysignal = ~noisysignal;
      tick();
    end
    noisysignal = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_out("reset_hold1", 1'b0, 1'b0, 1'b0);
    check("reset_hold.counter", {5'd0, dut.counter}, 8'd0);

    // Clean rise: noisysignal low at release, then high before edge k.
    noisysignal = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    pos_count = 0;
    neg_count = 0;
    noisysignal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();  // edges k .. k+4
      check_out($sformatf("rise_wait%0d", i), 1'b0, 1'b0, 1'b0);
    end
    tick();  // edge k+5
    check_out("rise_edge", 1'b1, 1'b1, 1'b0);
    tick();
    check_out("rise_after", 1'b1, 1'b0, 1'b0);
    check("rise_pos_count", 8'(pos_count), 8'd1);

    // Clean fall.
    pos_count = 0;
    neg_count = 0;
    noisysignal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("fall_wait%0d", i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_out("fall_edge", 1'b0, 1'b0, 1'b1);
    tick();
    check_out("fall_after", 1'b0, 1'b0, 1'b0);
    check("fall_neg_count", 8'(neg_count), 8'd1);
    check("fall_pos_count", 8'(pos_count), 8'd0);

    // Glitch rejection: sub-clock pulse, then a 3-clock pulse (one short of waittime+1).
    pos_count = 0;
    neg_count = 0;
    noisysignal = 1'b1;
    #10;
    noisysignal = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_out("glitch_short", 1'b0, 1'b0, 1'b0);
    noisysignal = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    noisysignal = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check({"glitch_cond", $sformatf("%0d", i)}, {7'd0, conditioned}, 8'd0);
    end
    check("glitch_pos_count", 8'(pos_count), 8'd0);
    check("glitch_neg_count", 8'(neg_count), 8'd0);

    // Bounce: 1,0,1 with 2-clock spacing, then hold 1.
    pos_count = 0;
    neg_count = 0;
    noisysignal = 1'b1;
    tick();
    tick();
    noisysignal = 1'b0;
    tick();
    tick();
    noisysignal = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();  // edges m .. m+4, m = edge sampling the final toggle
      check({"bounce_wait", $sformatf("%0d", i)}, {7'd0, conditioned}, 8'd0);
    end
    tick();
    check_out("bounce_edge", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("bounce_pos_count", 8'(pos_count), 8'd1);
    check("bounce_neg_count", 8'(neg_count), 8'd0);

    // Asynchronous reset between edges while conditioned=1.
    #5;
    reset = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 1'b0);
    check("async_reset.counter", {5'd0, dut.counter}, 8'd0);
    tick();
    reset = 1'b0;

    // Release with noisysignal still high: full latency from the first sampling edge.
    pos_count = 0;
    neg_count = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check({"release_wait", $sformatf("%0d", i)}, {7'd0, conditioned}, 8'd0);
    end
    tick();
    check_out("release_edge", 1'b1, 1'b1, 1'b0);
    tick();
    check("release_pos_count", 8'(pos_count), 8'd1);

    // Reset mid-count: start from conditioned=0, begin a rise, reset at counter=2.
    noisysignal = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_out("midcount_start", 1'b0, 1'b0, 1'b0);
    pos_count = 0;
    neg_count = 0;
    noisysignal = 1'b1;
    for (int i = 0; i < 4; i++) tick();  // edges m .. m+3
    check("midcount.counter_before", {5'd0, dut.counter}, 8'd2);
    #5;
    reset = 1'b1;
    #1;
    check_out("midcount_reset", 1'b0, 1'b0, 1'b0);
    check("midcount.counter_after", {5'd0, dut.counter}, 8'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check({"midcount_wait", $sformatf("%0d", i)}, {7'd0, conditioned}, 8'd0);
    end
    check("midcount_no_pulse", 8'(pos_count), 8'd0);
    tick();
    check_out("midcount_edge", 1'b1, 1'b1, 1'b0);
    tick();
    check_out("midcount_after", 1'b1, 1'b0, 1'b0);
    check("midcount_pos_count", 8'(pos_count), 8'd1);
    check("midcount_neg_count", 8'(neg_count), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
